// File: rtl/idli_decode_asm_m.sv
// rtl/idli_decode_asm_m.sv - lane-serial instruction/immediate assembler with output FIFO
module idli_decode_asm_m #(
    parameter int INSN_W     = 16,
    parameter int LANE_W     = 4,
    parameter int IMM_MARK_W = 3,
    parameter int DEPTH      = 2
) (
    input  logic              i_dcd_gck,
    input  logic              i_dcd_rst_n,
    input  logic              i_dcd_flush,
    input  logic [LANE_W-1:0] i_dcd_enc,
    input  logic              i_dcd_enc_vld,
    output logic              o_dcd_enc_rdy,
    output logic [INSN_W-1:0] o_dcd_insn,
    output logic [INSN_W-1:0] o_dcd_imm,
    output logic              o_dcd_imm_vld,
    output logic              o_dcd_vld,
    input  logic              i_dcd_rdy,
    output logic              o_dcd_busy
);

    localparam int BEATS = INSN_W / LANE_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [NW-1:0] FULL      = NW'(DEPTH);
    localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

    if (INSN_W % LANE_W != 0) begin : g_bad_lane
        $error("INSN_W must be a multiple of LANE_W");
    end
    if (IMM_MARK_W > INSN_W || IMM_MARK_W < 1) begin : g_bad_mark
        $error("IMM_MARK_W must be in 1..INSN_W");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("DEPTH must be at least 1");
    end

    typedef enum logic {ST_INSN = 1'b0, ST_IMM = 1'b1} state_t;

    state_t              state;
    logic [CW-1:0]       beat_cnt;
    logic [INSN_W-1:0]   pending;
    logic [INSN_W-1:0]   word_now;
    logic                accept;
    logic                last_beat;
    logic                mark;
    logic                push;
    logic                pop;

    logic [INSN_W-1:0]   insn_mem [DEPTH];
    logic [INSN_W-1:0]   imm_mem  [DEPTH];
    logic                immv_mem [DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [NW-1:0]       count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // The word completed by the beat on the bus: older beats sit above the live lane.
    if (LANE_W == INSN_W) begin : g_direct
        assign word_now = i_dcd_enc;
    end else begin : g_shift
        logic [INSN_W-LANE_W-1:0] sr;
        // Keep only the bits that will shift up; the oldest lane falls off the top.
        always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
            if (!i_dcd_rst_n) begin
                sr <= '0;
            end else if (accept) begin
                sr <= word_now[INSN_W-LANE_W-1:0];
            end
        end
        assign word_now = {sr, i_dcd_enc};
    end

    assign o_dcd_enc_rdy = (count != FULL);
    assign accept        = i_dcd_enc_vld && o_dcd_enc_rdy && !i_dcd_flush;
    assign last_beat     = (beat_cnt == LAST_BEAT);
    assign mark          = &word_now[IMM_MARK_W-1:0];
    assign push          = accept && last_beat && (state == ST_IMM || !mark);
    assign pop           = o_dcd_vld && i_dcd_rdy && !i_dcd_flush;
    assign o_dcd_busy    = (state == ST_IMM) || (beat_cnt != '0);

    // Beat counting and instruction/immediate pairing; flush abandons any partial word.
    always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            state    <= ST_INSN;
            beat_cnt <= '0;
            pending  <= '0;
        end else if (i_dcd_flush) begin
            state    <= ST_INSN;
            beat_cnt <= '0;
        end else if (accept) begin
            if (last_beat) begin
                beat_cnt <= '0;
                if (state == ST_INSN) begin
                    if (mark) begin
                        pending <= word_now;
                        state   <= ST_IMM;
                    end
                end else begin
                    state <= ST_INSN;
                end
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Storage for completed instructions; contents are only observed while counted valid.
    always_ff @(posedge i_dcd_gck) begin
        if (push) begin
            insn_mem[wr_ptr] <= (state == ST_IMM) ? pending : word_now;
            imm_mem[wr_ptr]  <= (state == ST_IMM) ? word_now : '0;
            immv_mem[wr_ptr] <= (state == ST_IMM);
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
    always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_dcd_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head presentation is gated by valid so an empty buffer reads as all zeros.
    always_comb begin
        o_dcd_vld     = (count != '0);
        o_dcd_insn    = '0;
        o_dcd_imm     = '0;
        o_dcd_imm_vld = 1'b0;
        if (o_dcd_vld) begin
            o_dcd_insn    = insn_mem[rd_ptr];
            o_dcd_imm     = imm_mem[rd_ptr];
            o_dcd_imm_vld = immv_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_idli_decode_asm_m.sv
// tb/tb_idli_decode_asm_m.sv - scoreboard bench for idli_decode_asm_m
module tb_idli_decode_asm_m;

    typedef struct {
        logic [15:0] insn;
        logic [15:0] imm;
        logic        immv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, flush2;
    logic [3:0]  enc;
    logic        enc_vld, enc_rdy;
    logic [15:0] insn, imm;
    logic        imm_vld, vld, rdy, busy;
    logic [15:0] enc2;
    logic        enc_vld2, enc_rdy2;
    logic [15:0] insn2, imm2;
    logic        imm_vld2, vld2, rdy2, busy2;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   n2 = 0;
    int   prev2 = 0;
    exp_t q1[$];
    exp_t q2[$];

    idli_decode_asm_m #(.INSN_W(16), .LANE_W(4), .IMM_MARK_W(3), .DEPTH(2)) dut (
        .i_dcd_gck(clk), .i_dcd_rst_n(rst_n), .i_dcd_flush(flush),
        .i_dcd_enc(enc), .i_dcd_enc_vld(enc_vld), .o_dcd_enc_rdy(enc_rdy),
        .o_dcd_insn(insn), .o_dcd_imm(imm), .o_dcd_imm_vld(imm_vld),
        .o_dcd_vld(vld), .i_dcd_rdy(rdy), .o_dcd_busy(busy));

    idli_decode_asm_m #(.INSN_W(16), .LANE_W(16), .IMM_MARK_W(3), .DEPTH(2)) dut_wide (
        .i_dcd_gck(clk), .i_dcd_rst_n(rst_n), .i_dcd_flush(flush2),
        .i_dcd_enc(enc2), .i_dcd_enc_vld(enc_vld2), .o_dcd_enc_rdy(enc_rdy2),
        .o_dcd_insn(insn2), .o_dcd_imm(imm2), .o_dcd_imm_vld(imm_vld2),
        .o_dcd_vld(vld2), .i_dcd_rdy(rdy2), .o_dcd_busy(busy2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor for the 4-bit lane instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n === 1'b1 && vld === 1'b1 && rdy === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = q1.pop_front();
                check("out_insn", 64'(insn), 64'(e.insn));
                check("out_imm", 64'(imm), 64'(e.imm));
                check("out_imm_vld", 64'(imm_vld), 64'(e.immv));
            end
        end
    end

    // Monitor for the wide lane instance; its outputs must come on consecutive cycles.
    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst_n === 1'b1 && vld2 === 1'b1 && rdy2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("wide_unexpected_out", 1, 0);
            end else begin
                e = q2.pop_front();
                check("wide_insn", 64'(insn2), 64'(e.insn));
                check("wide_imm", 64'(imm2), 64'(e.imm));
                check("wide_imm_vld", 64'(imm_vld2), 64'(e.immv));
                if (n2 > 0) check("wide_consecutive", 64'(cyc - prev2), 1);
                prev2 = cyc;
                n2++;
            end
        end
    end

    task automatic send_beat(input logic [3:0] b);
        int  waited;
        bit  ok;
        waited  = 0;
        enc     = b;
        enc_vld = 1'b1;
        forever begin
            @(negedge clk);
            ok = (enc_rdy === 1'b1);
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 200) begin
                check("beat_timeout", 0, 1);
                break;
            end
        end
        enc_vld = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) send_beat(w[4*i +: 4]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q1.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(q1.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; flush2 = 1'b0;
        enc = '0; enc_vld = 1'b0; rdy = 1'b1;
        enc2 = '0; enc_vld2 = 1'b0; rdy2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 64'(vld), 0);
        check("rst_insn", 64'(insn), 0);
        check("rst_imm", 64'(imm), 0);
        check("rst_imm_vld", 64'(imm_vld), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_enc_rdy", 64'(enc_rdy), 1);
        check("rst_wide_enc_rdy", 64'(enc_rdy2), 1);
        rst_n = 1'b1;

        // Plain instruction, valid the cycle after the final beat.
        q1.push_back('{16'hC123, 16'h0000, 1'b0});
        send_word(16'hC123);
        check("plain_latency_vld", 64'(vld), 1);
        check("plain_busy_done", 64'(busy), 0);

        // Immediate pairing: nothing emerges until the immediate word is complete.
        send_beat(4'hF); check("imm_busy_b1", 64'(busy), 1); check("imm_novld_b1", 64'(vld), 0);
        send_beat(4'h0); check("imm_busy_b2", 64'(busy), 1);
        send_beat(4'h0); check("imm_busy_b3", 64'(busy), 1);
        send_beat(4'h7); check("imm_busy_b4", 64'(busy), 1); check("imm_novld_b4", 64'(vld), 0);
        q1.push_back('{16'hF007, 16'hBEEF, 1'b1});
        send_beat(4'hB); check("imm_busy_b5", 64'(busy), 1); check("imm_novld_b5", 64'(vld), 0);
        send_beat(4'hE); check("imm_busy_b6", 64'(busy), 1);
        send_beat(4'hE); check("imm_busy_b7", 64'(busy), 1);
        send_beat(4'hF); check("imm_busy_b8", 64'(busy), 0); check("imm_latency_vld", 64'(vld), 1);
        drain();

        // Backpressure: buffer fills after two words and the stream stalls.
        rdy = 1'b0;
        q1.push_back('{16'h1111, 16'h0000, 1'b0});
        q1.push_back('{16'h2222, 16'h0000, 1'b0});
        q1.push_back('{16'h3333, 16'h0000, 1'b0});
        send_word(16'h1111);
        for (int i = 0; i < 3; i++) send_beat(4'h2);
        check("bp_rdy_before_full", 64'(enc_rdy), 1);
        send_beat(4'h2);
        check("bp_rdy_full", 64'(enc_rdy), 0);
        check("bp_head", 64'(insn), 64'h1111);
        enc = 4'h3; enc_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_stall_busy", 64'(busy), 0);
        check("bp_stall_rdy", 64'(enc_rdy), 0);
        check("bp_stall_head", 64'(insn), 64'h1111);
        rdy = 1'b1;
        send_word(16'h3333);
        drain();

        // Flush drops a buffered word and a half-received immediate.
        rdy = 1'b0;
        send_word(16'h4444);
        send_word(16'hF007);
        send_beat(4'hB);
        send_beat(4'hE);
        check("flush_pre_busy", 64'(busy), 1);
        check("flush_pre_vld", 64'(vld), 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 0);
        check("flush_vld", 64'(vld), 0);
        check("flush_rdy", 64'(enc_rdy), 1);
        rdy = 1'b1;
        q1.push_back('{16'h1234, 16'h0000, 1'b0});
        send_word(16'h1234);
        drain();

        // Asynchronous reset in the middle of a word with a word buffered.
        rdy = 1'b0;
        send_word(16'h9999);
        send_beat(4'hA);
        send_beat(4'hB);
        check("rstmid_pre_vld", 64'(vld), 1);
        check("rstmid_pre_busy", 64'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_vld", 64'(vld), 0);
        check("rstmid_insn", 64'(insn), 0);
        check("rstmid_imm", 64'(imm), 0);
        check("rstmid_imm_vld", 64'(imm_vld), 0);
        check("rstmid_busy", 64'(busy), 0);
        check("rstmid_enc_rdy", 64'(enc_rdy), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy = 1'b1;
        q1.push_back('{16'h5678, 16'h0000, 1'b0});
        send_word(16'h5678);
        drain();

        // Wide lane: one beat per word, immediate pairing back to back.
        q2.push_back('{16'h0007, 16'h1234, 1'b1});
        q2.push_back('{16'h0042, 16'h0000, 1'b0});
        enc2 = 16'h0007; enc_vld2 = 1'b1;
        @(posedge clk); #1;
        check("wide_busy_after_mark", 64'(busy2), 1);
        enc2 = 16'h1234;
        @(posedge clk); #1;
        check("wide_latency_vld", 64'(vld2), 1);
        enc2 = 16'h0042;
        @(posedge clk); #1;
        enc_vld2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("wide_pops", 64'(n2), 2);
        check("wide_sb_empty", 64'(q2.size()), 0);
        check("sb_empty", 64'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
